// File: rtl/cpu_mem_pkg.sv
// Shared CPU data-bus definitions for MMIO peripherals.
// Holds the MEM_type transfer-size encodings, the UART register offsets, the
// STATUS bit positions and the transmit FSM state encoding.
// Optional feature macro used by importers: UART_TX_PARITY_EN.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    MemByte = 3'b000,
    MemHalf = 3'b001,
    MemWord = 3'b010
  } mem_type_e;

  localparam logic [31:0] TxdataOffset = 32'h0000_0000;
  localparam logic [31:0] StatusOffset = 32'h0000_0004;

  localparam int unsigned StatFullBit  = 0;
  localparam int unsigned StatEmptyBit = 1;
  localparam int unsigned StatBusyBit  = 2;
  localparam int unsigned StatOvfBit   = 3;
  localparam int unsigned StatCountLsb = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
// Ports: CLK, Reset (async, active-high), push/wdata (write side),
// pop/rdata (read side, rdata shows the head combinationally),
// full, empty, count (fill level 0..DEPTH).
// A push while full is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter.
// Registers: TXDATA at BASE_ADDR+0 (store pushes byte, load returns 0),
// STATUS at BASE_ADDR+4 (load: count/overflow/busy/empty/full, store clears overflow).
// Ports: CLK, Reset (async, active-high), MEM_addr/MEM_WR_out/MEM_type/MEM_rd_en/
// MEM_wr_en (CPU bus in), MEM_data (combinational load data, 0 when not selected),
// tx (registered serial line, idle high).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx
  import cpu_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_WR_out,
  input  logic [2:0]  MEM_type,
  input  logic        MEM_rd_en,
  input  logic        MEM_wr_en,
  output logic [31:0] MEM_data,
  output logic        tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  tx_state_e     state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          hit, is_status, is_txdata, baud_last;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic          unused_bits;

  // Transfer size and byte offset do not affect these byte-wide registers.
  assign unused_bits = ^{MEM_type, MEM_addr[1:0], MEM_WR_out[31:8]};

  assign hit       = (MEM_addr[31:3] == BASE_ADDR[31:3]);
  assign is_status = hit && (MEM_addr[2] == StatusOffset[2]);
  assign is_txdata = hit && (MEM_addr[2] == TxdataOffset[2]);
  assign fifo_push = MEM_wr_en && is_txdata;
  assign baud_last = (baud_q == 16'(CLKS_PER_BIT - 1));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (fifo_push),
    .wdata (MEM_WR_out[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_rdata;
          baud_d   = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        baud_d = baud_q + 16'd1;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        baud_d = baud_q + 16'd1;
        if (baud_last) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        baud_d = baud_q + 16'd1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        baud_d = baud_q + 16'd1;
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next frame so there is no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_rdata;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is computed from the next state so tx can be a plain flop.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_d[bit_d];
      StParity: tx_d = ^data_d;
      default:  tx_d = 1'b1;
    endcase

    ovf_d = ovf_q;
    if (MEM_wr_en && is_status) ovf_d = 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    status                        = '0;
    status[StatCountLsb +: 8]     = 8'(fifo_count);
    status[StatOvfBit]            = ovf_q;
    status[StatBusyBit]           = (state_q != StIdle);
    status[StatEmptyBit]          = fifo_empty;
    status[StatFullBit]           = fifo_full;
  end

  assign MEM_data = (MEM_rd_en && is_status) ? status : 32'h0;
  assign tx       = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// The reference model keeps the FIFO as a byte queue and the serial line as a
// queue of expected per-cycle line levels built from whole frames.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] MEM_addr = '0;
  logic [31:0] MEM_WR_out = '0;
  logic [2:0]  MEM_type = '0;
  logic        MEM_rd_en = 1'b0;
  logic        MEM_wr_en = 1'b0;
  logic [31:0] MEM_data;
  logic        tx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pending[$];
  bit         line[$];
  bit         m_ovf  = 1'b0;
  bit         m_busy = 1'b0;
  bit         exp_tx = 1'b1;

  always #5 CLK = ~CLK;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .MEM_addr   (MEM_addr),
    .MEM_WR_out (MEM_WR_out),
    .MEM_type   (MEM_type),
    .MEM_rd_en  (MEM_rd_en),
    .MEM_wr_en  (MEM_wr_en),
    .MEM_data   (MEM_data),
    .tx         (tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    int c;
    c = pending.size();
    return {16'h0, 8'(c), 4'h0, m_ovf, m_busy, (c == 0), (c == DEPTH)};
  endfunction

  task automatic push_bit(input bit v);
    for (int i = 0; i < CPB; i++) line.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b);
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) push_bit(b[i]);
`ifdef UART_TX_PARITY_EN
    push_bit(^b);
`endif
    push_bit(1'b1);
  endtask

  task automatic model_reset();
    pending.delete();
    line.delete();
    m_ovf  = 1'b0;
    m_busy = 1'b0;
    exp_tx = 1'b1;
  endtask

  // One rising edge: a frame starts when the line has nothing left to send.
  task automatic model_edge(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    logic hit;
    hit = (addr[31:3] == BASE[31:3]);
    if (line.size() == 0 && pending.size() != 0) add_frame(pending.pop_front());
    if (wr && hit && !addr[2]) begin
      if (pending.size() < DEPTH) pending.push_back(wd[7:0]);
      else m_ovf = 1'b1;
    end
    if (wr && hit && addr[2]) m_ovf = 1'b0;
    if (line.size() != 0) begin
      exp_tx = line.pop_front();
      m_busy = 1'b1;
    end else begin
      exp_tx = 1'b1;
      m_busy = 1'b0;
    end
  endtask

  // Called at posedge+1; drives one bus cycle and checks load data and line.
  task automatic step(input logic wr, input logic rd, input logic [31:0] addr,
                      input logic [31:0] wd);
    logic [31:0] exp_md;
    MEM_wr_en  = wr;
    MEM_rd_en  = rd;
    MEM_addr   = addr;
    MEM_WR_out = wd;
    MEM_type   = 3'($urandom_range(0, 2));
    @(negedge CLK);
    exp_md = (rd && addr[31:3] == BASE[31:3] && addr[2]) ? m_status() : 32'h0;
    chk("mem_data", MEM_data, exp_md);
    @(posedge CLK);
    model_edge(wr, addr, wd);
    #1;
    chk("tx", 32'(tx), 32'(exp_tx));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 3) * 4), $urandom);
  endtask

  task automatic wr_tx(input logic [31:0] wd);
    step(1'b1, 1'b0, BASE, wd);
  endtask

  task automatic rd_status();
    step(1'b0, 1'b1, BASE + 32'd4, 32'h0);
  endtask

  initial begin
    logic [31:0] addr_tbl [8];
    int          budget;
    addr_tbl = '{BASE, BASE, BASE, BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'd2,
                 32'h1234_5678};

    // Reset state, including async read of STATUS while held in reset.
    MEM_rd_en = 1'b1;
    MEM_addr  = BASE + 32'd4;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_tx", 32'(tx), 32'h1);
    chk("reset_status", MEM_data, 32'h0000_0002);
    Reset = 1'b0;
    model_reset();
    rd_status();

    // Single frame of 0xA5 from the upper bits-ignored word store.
    wr_tx(32'h0000_00A5);
    idle(45);

    // Three back-to-back frames; STATUS sampled mid first frame and at the end.
    wr_tx(32'h11);
    wr_tx(32'h22);
    wr_tx(32'h33);
    idle(6);
    rd_status();
    idle(125);
    rd_status();

    // Overflow: six stores into a depth-4 FIFO, then clear via STATUS store.
    for (int i = 0; i < 6; i++) wr_tx($urandom);
    rd_status();
    step(1'b1, 1'b0, BASE + 32'd4, 32'hFFFF_FFFF);
    rd_status();
    idle(210);

    // Random traffic over hits, misses and ignored low address bits.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           addr_tbl[$urandom_range(0, 7)], $urandom);
    budget = 0;
    while ((line.size() != 0 || pending.size() != 0) && budget < 400) begin
      idle(1);
      budget++;
    end
    chk("drain_budget", 32'(line.size() + pending.size()), 32'h0);

    // Reset in the middle of DATA with a byte still queued.
    wr_tx(32'h5A);
    wr_tx(32'hC3);
    idle(8);
    #3 Reset = 1'b1;
    #1;
    chk("async_reset_tx", 32'(tx), 32'h1);
    model_reset();
    @(posedge CLK);
    #1 Reset = 1'b0;
    rd_status();
    idle(50);

    // First push after reset keeps the one-edge latency.
    wr_tx($urandom);
    idle(45);

    // Decode: BASE+8 and TXDATA loads read 0, BASE+8 store is ignored.
    step(1'b0, 1'b1, BASE + 32'd8, 32'h0);
    step(1'b0, 1'b1, BASE, 32'h0);
    step(1'b1, 1'b0, BASE + 32'd8, 32'h77);
    rd_status();
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
